// File: rtl/abp_packet_tx_if.sv
// Frame-side valid/ready handshake and byte-wide AXI-Stream bundles for the ABP packet transmitter.
// The slave side of abp_frame_if consumes frames; the master side of axis_byte_if drives the stream.

interface abp_frame_if #(
  parameter int VALUE_SIZE = 4
);
  logic                    valid;
  logic [VALUE_SIZE*8-1:0] value;
  logic                    alt_bit;
  logic                    ready;

  modport master (output valid, output value, output alt_bit, input ready);
  modport slave  (input valid, input value, input alt_bit, output ready);
endinterface

interface axis_byte_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tvalid;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic                  tready;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/abp_packet_tx.sv
// Serializes one ABP frame (big-endian value, padding, alternating bit in the last byte)
// into a fixed-length byte packet on AXI-Stream, with an optional inter-frame gap.

module abp_packet_tx #(
  parameter int         DATA_WIDTH  = 8,
  parameter int         VALUE_SIZE  = 4,
  parameter int         PACKET_SIZE = 64,
  parameter logic [7:0] PAD_BYTE    = 8'h00,
  parameter int         IFG_CYCLES  = 0
) (
  input  logic        aclk,
  input  logic        resetn,
  abp_frame_if.slave  abp_rx,
  axis_byte_if.master eth_tx,
  output logic        busy,
  output logic [15:0] packet_count
);

  localparam int CW = (PACKET_SIZE > 1) ? $clog2(PACKET_SIZE) : 1;
  localparam int VW = VALUE_SIZE * 8;
  localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_K = CW'(PACKET_SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         k_q, k_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [VW-1:0]         value_q, value_d;
  logic                  bit_q, bit_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  busy_q, busy_d;
  logic [15:0]           count_q, count_d;
  logic [CW-1:0]         k_inc_s;

  // Byte k of the packet: value MSB first, then padding, alternating bit in the final byte.
  function automatic logic [7:0] packet_byte(input logic [CW-1:0] k,
                                             input logic [VW-1:0] value,
                                             input logic          alt_bit);
    logic [VW-1:0] shifted;
    logic [7:0]    b;
    shifted = '0;
    if (k == LAST_K) begin
      b = {7'b0000000, alt_bit};
    end else if (k < CW'(VALUE_SIZE)) begin
      shifted = value >> (8 * (VALUE_SIZE - 1 - int'(k)));
      b       = shifted[7:0];
    end else begin
      b = PAD_BYTE;
    end
    return b;
  endfunction

  assign k_inc_s = k_q + CW'(1);

  // Next-state and next-output logic; the stream registers are loaded one beat ahead.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    gap_d    = gap_q;
    value_d  = value_q;
    bit_d    = bit_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    count_d  = count_q;
    case (state_q)
      ST_IDLE: begin
        if (abp_rx.valid) begin
          value_d  = abp_rx.value;
          bit_d    = abp_rx.alt_bit;
          k_d      = '0;
          tvalid_d = 1'b1;
          tdata_d  = DATA_WIDTH'(packet_byte('0, abp_rx.value, abp_rx.alt_bit));
          tlast_d  = (LAST_K == '0);
          state_d  = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (eth_tx.tready) begin
          if (tlast_q) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = '0;
            count_d  = count_q + 16'd1;
            if (IFG_CYCLES > 0) begin
              gap_d   = GW'(IFG_CYCLES - 1);
              state_d = ST_GAP;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            k_d     = k_inc_s;
            tdata_d = DATA_WIDTH'(packet_byte(k_inc_s, value_q, bit_q));
            tlast_d = (k_inc_s == LAST_K);
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        tdata_d  = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      gap_q    <= '0;
      value_q  <= '0;
      bit_q    <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      count_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      gap_q    <= gap_d;
      value_q  <= value_d;
      bit_q    <= bit_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
    end
  end

  // Ready is gated by reset so upstream never sees an acceptance while the block is held.
  assign abp_rx.ready  = resetn && (state_q == ST_IDLE);
  assign eth_tx.tvalid = tvalid_q;
  assign eth_tx.tdata  = tdata_q;
  assign eth_tx.tlast  = tlast_q;
  assign busy          = busy_q;
  assign packet_count  = count_q;

endmodule

// File: tb/tb_abp_packet_tx.sv
// Directed-plus-random bench for abp_packet_tx: packet contents, timing, backpressure,
// inter-frame gap, mid-packet reset and packet counter wrap, checked against a byte-list model.

module tb_abp_packet_tx;

  localparam int VS = 4;
  localparam int PS = 64;
  localparam logic [7:0] PAD = 8'h00;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic resetn;
  logic sel;
  logic valid_s, bit_s, tready_s;
  logic [31:0] value_s;

  abp_frame_if #(.VALUE_SIZE(VS)) f0 ();
  abp_frame_if #(.VALUE_SIZE(VS)) f1 ();
  axis_byte_if #(.DATA_WIDTH(8))  s0 ();
  axis_byte_if #(.DATA_WIDTH(8))  s1 ();

  logic        busy0, busy1;
  logic [15:0] cnt0, cnt1;

  abp_packet_tx #(.DATA_WIDTH(8), .VALUE_SIZE(VS), .PACKET_SIZE(PS), .PAD_BYTE(PAD), .IFG_CYCLES(0)) dut0 (
    .aclk(aclk), .resetn(resetn), .abp_rx(f0), .eth_tx(s0), .busy(busy0), .packet_count(cnt0));
  abp_packet_tx #(.DATA_WIDTH(8), .VALUE_SIZE(VS), .PACKET_SIZE(PS), .PAD_BYTE(PAD), .IFG_CYCLES(3)) dut1 (
    .aclk(aclk), .resetn(resetn), .abp_rx(f1), .eth_tx(s1), .busy(busy1), .packet_count(cnt1));

  assign f0.valid   = !sel && valid_s;
  assign f0.value   = value_s;
  assign f0.alt_bit = bit_s;
  assign f1.valid   = sel && valid_s;
  assign f1.value   = value_s;
  assign f1.alt_bit = bit_s;
  assign s0.tready  = sel ? 1'b1 : tready_s;
  assign s1.tready  = sel ? tready_s : 1'b1;

  logic        tv, tl, rdy, bsy;
  logic [7:0]  td;
  logic [15:0] pc;
  assign tv  = sel ? s1.tvalid : s0.tvalid;
  assign tl  = sel ? s1.tlast  : s0.tlast;
  assign td  = sel ? s1.tdata  : s0.tdata;
  assign rdy = sel ? f1.ready  : f0.ready;
  assign bsy = sel ? busy1     : busy0;
  assign pc  = sel ? cnt1      : cnt0;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [15:0] exp_cnt [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
    cyc++;
  endtask

  // Expected byte k of a packet, straight from the frame layout rules.
  function automatic logic [7:0] ref_byte(input logic [31:0] v, input logic b, input int k);
    logic [31:0] q;
    if (k == PS - 1) return {7'd0, b};
    if (k < VS) begin
      q = (v / (32'd1 << (8 * (VS - 1 - k)))) % 32'd256;
      return q[7:0];
    end
    return PAD;
  endfunction

  task automatic send_packet(input logic [31:0] v, input logic b, input int stall_pct,
                             input logic hold, input logic [31:0] v_after, input logic b_after,
                             input int abort_at, output int wait_n, output int first_c, output int last_c);
    logic [7:0] exp_q[$];
    logic [7:0] hd;
    logic       hl;
    logic       stalled;
    int         idx;
    int         guard;
    hd = 8'd0;
    hl = 1'b0;
    for (int k = 0; k < PS; k++) exp_q.push_back(ref_byte(v, b, k));
    valid_s  = 1'b1;
    value_s  = v;
    bit_s    = b;
    tready_s = 1'b1;
    wait_n   = 0;
    while (rdy !== 1'b1 && wait_n < 300) begin
      tick();
      wait_n++;
    end
    chk("accept_timeout", 32'(wait_n < 300), 32'd1);
    tick();
    valid_s = hold;
    value_s = v_after;
    bit_s   = b_after;
    idx     = 0;
    stalled = 1'b0;
    guard   = 0;
    first_c = cyc;
    last_c  = cyc;
    while (idx < PS && idx != abort_at && guard < 1000) begin
      chk("tvalid_in_packet", 32'(tv), 32'd1);
      if (tv !== 1'b1) break;
      chk("busy_send", 32'(bsy), 32'd1);
      chk("ready_send", 32'(rdy), 32'd0);
      if (stalled) begin
        chk("stall_tdata", 32'(td), 32'(hd));
        chk("stall_tlast", 32'(tl), 32'(hl));
      end
      tready_s = ($urandom_range(99) >= stall_pct);
      if (tready_s) begin
        chk("tdata", 32'(td), 32'(exp_q[idx]));
        chk("tlast", 32'(tl), 32'(idx == PS - 1));
        if (idx == PS - 1) last_c = cyc;
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        hd      = td;
        hl      = tl;
      end
      tick();
      guard++;
    end
    chk("packet_progress", 32'(idx == PS || idx == abort_at), 32'd1);
    tready_s = 1'b1;
    if (idx == PS) exp_cnt[sel] = exp_cnt[sel] + 16'd1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, fa, la, fb, lb;
    logic [31:0] ra, rb;
    sel        = 1'b0;
    valid_s    = 1'b0;
    value_s    = 32'd0;
    bit_s      = 1'b0;
    tready_s   = 1'b1;
    resetn     = 1'b0;
    exp_cnt[0] = 16'd0;
    exp_cnt[1] = 16'd0;
    tick();
    tick();

    // Reset state
    chk("rst_tvalid", 32'(tv), 32'd0);
    chk("rst_tdata", 32'(td), 32'd0);
    chk("rst_tlast", 32'(tl), 32'd0);
    chk("rst_busy", 32'(bsy), 32'd0);
    chk("rst_count", 32'(pc), 32'd0);
    chk("rst_ready_gated", 32'(rdy), 32'd0);
    resetn = 1'b1;
    tick();
    chk("ready_after_release", 32'(rdy), 32'd1);

    // Single frame with default parameters and no backpressure
    send_packet(32'hDEADBEEF, 1'b1, 0, 1'b0, 32'h12345678, 1'b0, -1, w, fa, la);
    chk("t1_accept_wait", 32'(w), 32'd0);
    chk("t1_last_minus_first", 32'(la - fa), 32'(PS - 1));
    chk("t1_count", 32'(pc), 32'd1);
    chk("t1_idle_tvalid", 32'(tv), 32'd0);
    chk("t1_idle_ready", 32'(rdy), 32'd1);
    chk("t1_idle_busy", 32'(bsy), 32'd0);

    // Back-to-back frames with valid held high
    ra = $urandom;
    rb = $urandom;
    send_packet(ra, 1'b0, 0, 1'b1, rb, 1'b1, -1, w, fa, la);
    chk("b2b_ready_after_tlast", 32'(rdy), 32'd1);
    chk("b2b_count_first", 32'(pc), 32'(exp_cnt[0]));
    send_packet(rb, 1'b1, 0, 1'b0, ~rb, 1'b0, -1, w, fb, lb);
    chk("b2b_accept_wait", 32'(w), 32'd0);
    chk("b2b_first_beat_spacing", 32'(fb - la), 32'd2);
    chk("b2b_count", 32'(pc), 32'd3);

    // Random backpressure; inputs change right after acceptance
    for (int p = 0; p < 3; p++) begin
      ra = $urandom;
      send_packet(ra, 1'($urandom_range(1)), 50, 1'b0, ~ra, 1'($urandom_range(1)), -1, w, fa, la);
      chk("stall_count", 32'(pc), 32'(exp_cnt[0]));
    end

    // Inter-frame gap of 3 cycles on the second instance
    sel = 1'b1;
    ra  = $urandom;
    send_packet(ra, 1'b1, 0, 1'b0, 32'd0, 1'b0, -1, w, fa, la);
    chk("ifg_count", 32'(pc), 32'd1);
    for (int g = 0; g < 3; g++) begin
      chk("ifg_ready_low", 32'(rdy), 32'd0);
      chk("ifg_busy_high", 32'(bsy), 32'd1);
      chk("ifg_tvalid_low", 32'(tv), 32'd0);
      tick();
    end
    chk("ifg_ready_back", 32'(rdy), 32'd1);
    chk("ifg_busy_clear", 32'(bsy), 32'd0);
    rb = $urandom;
    send_packet(rb, 1'b0, 30, 1'b0, 32'd0, 1'b0, -1, w, fb, lb);
    chk("ifg_first_beat_spacing", 32'((fb - la) >= 5), 32'd1);
    chk("ifg_count_second", 32'(pc), 32'd2);

    // Reset while byte 30 is on the bus
    sel = 1'b0;
    ra  = $urandom;
    send_packet(ra, 1'b1, 0, 1'b0, 32'd0, 1'b0, 30, w, fa, la);
    resetn = 1'b0;
    tick();
    exp_cnt[0] = 16'd0;
    exp_cnt[1] = 16'd0;
    chk("mid_rst_tvalid", 32'(tv), 32'd0);
    chk("mid_rst_tlast", 32'(tl), 32'd0);
    chk("mid_rst_busy", 32'(bsy), 32'd0);
    chk("mid_rst_count", 32'(pc), 32'd0);
    resetn = 1'b1;
    tick();
    chk("mid_rst_ready", 32'(rdy), 32'd1);
    send_packet(32'h00000001, 1'b1, 0, 1'b0, 32'hFFFFFFFF, 1'b0, -1, w, fa, la);
    chk("post_rst_len", 32'(la - fa), 32'(PS - 1));
    chk("post_rst_count", 32'(pc), 32'd1);

    // Counter wrap: preload the count, then complete one more packet
    force dut0.count_q = 16'hFFFF;
    tick();
    tick();
    release dut0.count_q;
    tick();
    chk("wrap_preload", 32'(pc), 32'h0000FFFF);
    exp_cnt[0] = 16'hFFFF;
    ra = $urandom;
    send_packet(ra, 1'b0, 20, 1'b0, 32'd0, 1'b0, -1, w, fa, la);
    chk("wrap_count", 32'(pc), 32'(exp_cnt[0]));
    chk("wrap_zero", 32'(pc), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
